mem_port_arbiter: RTL

- Shares one single-port, variable-latency memory between two requesters: instruction fetch (port 0, read-only) and the execute stage load/store path (port 1, read/write).
- Accepts one request at a time through a valid/ready handshake and holds it on the memory bus until the memory acknowledges.
- Returns the response to the requester that owns the transaction.
- A watchdog ends any transaction the memory never acknowledges, so the pipeline cannot hang.

---
 rtl/mem_port_arbiter.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one variable-latency memory between fetch (port 0) and load/store (port 1); one transaction in flight.
// Grant takes one edge, response pulses the cycle after ack; losers hold valid until ready; watchdog returns all-ones.
module mem_port_arbiter #(
    parameter int DATA_PRIORITY = 1,
    parameter int TIMEOUT       = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid_i,
    output logic        if_ready_o,
    input  logic [31:0] if_addr_i,
    output logic        if_rvalid_ro,
    output logic [31:0] if_rdata_ro,
    input  logic        dm_valid_i,
    output logic        dm_ready_o,
    input  logic [31:0] dm_addr_i,
    input  logic [31:0] dm_wdata_i,
    input  logic        dm_write_i,
    input  logic [1:0]  dm_width_i,
    output logic        dm_rvalid_ro,
    output logic [31:0] dm_rdata_ro,
    output logic        mem_req_ro,
    output logic [31:0] mem_addr_ro,
    output logic [31:0] mem_wdata_ro,
    output logic        mem_write_ro,
    output logic [1:0]  mem_width_ro,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        err_ro
);
    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_BUSY  = 1'b1;
    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic        owner_q, owner_d;
    logic        rr_q, rr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        mem_req_q, mem_req_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        mem_write_q, mem_write_d;
    logic [1:0]  mem_width_q, mem_width_d;
    logic        if_rvalid_q, if_rvalid_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic        dm_rvalid_q, dm_rvalid_d;
    logic [31:0] dm_rdata_q, dm_rdata_d;
    logic        err_q, err_d;

    logic        idle;
    logic        grant_if;
    logic        grant_dm;
    logic        timeout_hit;
    logic [31:0] rsp_dat;

    assign idle = (state_q == ST_IDLE);

    // rr_q names the port that wins the next tie in round-robin mode
    always_comb begin
        grant_dm = 1'b0;
        if (dm_valid_i && !if_valid_i) begin
            grant_dm = 1'b1;
        end else if (dm_valid_i && if_valid_i) begin
            grant_dm = (DATA_PRIORITY != 0) ? 1'b1 : rr_q;
        end
    end

    assign grant_if    = if_valid_i && !grant_dm;
    assign if_ready_o  = idle && grant_if;
    assign dm_ready_o  = idle && grant_dm;
    assign timeout_hit = (cnt_q == CNT_LAST);
    assign rsp_dat     = mem_ack_i ? mem_rdata_i : 32'hFFFF_FFFF;

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_d        = rr_q;
        cnt_d       = cnt_q;
        mem_req_d   = mem_req_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_write_d = mem_write_q;
        mem_width_d = mem_width_q;
        if_rvalid_d = 1'b0;
        if_rdata_d  = if_rdata_q;
        dm_rvalid_d = 1'b0;
        dm_rdata_d  = dm_rdata_q;
        err_d       = err_q;
        if (state_q == ST_IDLE) begin
            if (if_ready_o || dm_ready_o) begin
                state_d     = ST_BUSY;
                owner_d     = dm_ready_o;
                rr_d        = if_ready_o;
                cnt_d       = '0;
                mem_req_d   = 1'b1;
                mem_addr_d  = dm_ready_o ? dm_addr_i : if_addr_i;
                mem_wdata_d = dm_ready_o ? dm_wdata_i : 32'd0;
                mem_write_d = dm_ready_o && dm_write_i;
                mem_width_d = dm_ready_o ? dm_width_i : 2'b10;
            end
        end else if (mem_ack_i || timeout_hit) begin
            // an ack landing on the timeout cycle still counts as a normal completion
            state_d   = ST_IDLE;
            cnt_d     = '0;
            mem_req_d = 1'b0;
            if (owner_q) begin
                dm_rvalid_d = 1'b1;
                dm_rdata_d  = rsp_dat;
            end else begin
                if_rvalid_d = 1'b1;
                if_rdata_d  = rsp_dat;
            end
            if (!mem_ack_i) begin
                err_d = 1'b1;
            end
        end else begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            owner_q     <= 1'b0;
            rr_q        <= 1'b1;
            cnt_q       <= '0;
            mem_req_q   <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_write_q <= 1'b0;
            mem_width_q <= 2'b00;
            if_rvalid_q <= 1'b0;
            if_rdata_q  <= '0;
            dm_rvalid_q <= 1'b0;
            dm_rdata_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_q        <= rr_d;
            cnt_q       <= cnt_d;
            mem_req_q   <= mem_req_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_write_q <= mem_write_d;
            mem_width_q <= mem_width_d;
            if_rvalid_q <= if_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            dm_rvalid_q <= dm_rvalid_d;
            dm_rdata_q  <= dm_rdata_d;
            err_q       <= err_d;
        end
    end

    assign mem_req_ro   = mem_req_q;
    assign mem_addr_ro  = mem_addr_q;
    assign mem_wdata_ro = mem_wdata_q;
    assign mem_write_ro = mem_write_q;
    assign mem_width_ro = mem_width_q;
    assign if_rvalid_ro = if_rvalid_q;
    assign if_rdata_ro  = if_rdata_q;
    assign dm_rvalid_ro = dm_rvalid_q;
    assign dm_rdata_ro  = dm_rdata_q;
    assign err_ro       = err_q;
endmodule
